// File: rtl/em_step_sequencer.sv
// One-hot T-state sequencer with run/pause/halt control for the 8-bit CPU.
// Optional instruction counter enabled by defining SEQ_ICOUNT_EN.
module em_step_sequencer #(
   parameter int NSTEPS = 6
) (
   input  logic        clk,
   input  logic        nclr,
   input  logic        start,
   input  logic        single,
   input  logic        step_btn,
   input  logic        step_end,
   input  logic        halt_req,
   output logic [3:0]  step,
   output logic [15:0] step_oh,
   output logic        ctl_en,
   output logic        instr_done,
   output logic        halted,
   output logic [15:0] icount
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [3:0] LAST = 4'(NSTEPS - 1);

   state_t state;
   logic   btn_q;
   logic   btn_edge;
   logic   last_step;

   assign btn_edge  = step_btn & ~btn_q;
   assign last_step = step_end | (step == LAST);

   // In PAUSE a press only counts while still in single-step mode
   assign ctl_en = (state == RUN) |
                   ((state == PAUSE) & single & btn_edge);

   assign instr_done = ctl_en & last_step & ~halt_req;
   assign halted     = (state == HALT);

   always_comb begin
      step_oh = 16'd0;
      if (state == RUN || state == PAUSE)
         step_oh = 16'd1 << step;
   end

   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         state <= IDLE;
         step  <= 4'd0;
         btn_q <= 1'b0;
      end else begin
         btn_q <= step_btn;
         unique case (state)
            IDLE, HALT: begin
               if (start) begin
                  state <= single ? PAUSE : RUN;
                  step  <= 4'd0;
               end
            end
            RUN, PAUSE: begin
               if (ctl_en) begin
                  if (halt_req) begin
                     state <= HALT;
                     step  <= 4'd0;
                  end else begin
                     step  <= last_step ? 4'd0 : step + 4'd1;
                     state <= single ? PAUSE : RUN;
                  end
               end else if (state == PAUSE && !single) begin
                  state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SEQ_ICOUNT_EN
   logic [15:0] icount_q;

   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr)
         icount_q <= 16'd0;
      else if (instr_done)
         icount_q <= icount_q + 16'd1;
   end

   assign icount = icount_q;
`else
   assign icount = 16'd0;
`endif

endmodule

// File: tb/tb_em_step_sequencer.sv
// Directed self-checking bench for em_step_sequencer (NSTEPS=6).
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_em_step_sequencer;

   logic        clk;
   logic        nclr;
   logic        start;
   logic        single;
   logic        step_btn;
   logic        step_end;
   logic        halt_req;
   logic [3:0]  step;
   logic [15:0] step_oh;
   logic        ctl_en;
   logic        instr_done;
   logic        halted;
   logic [15:0] icount;

   int total;
   int bad;
   int exp_icount;

   em_step_sequencer #(.NSTEPS(6)) dut (
      .clk        (clk),
      .nclr       (nclr),
      .start      (start),
      .single     (single),
      .step_btn   (step_btn),
      .step_end   (step_end),
      .halt_req   (halt_req),
      .step       (step),
      .step_oh    (step_oh),
      .ctl_en     (ctl_en),
      .instr_done (instr_done),
      .halted     (halted),
      .icount     (icount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [15:0] act,
                      input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic do_reset();
      start = 0; single = 0; step_btn = 0;
      step_end = 0; halt_req = 0;
      nclr = 0;
      #1;
      adv();
      nclr = 1;
      exp_icount = 0;
      #1;
   endtask

   task automatic check_icount(input string name);
`ifdef SEQ_ICOUNT_EN
      chk(name, icount, 16'(exp_icount));
`else
      chk(name, icount, 16'd0);
`endif
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_step", {12'd0, step}, 16'd0);
      chk("rst_oh", step_oh, 16'd0);
      chk("rst_ctl", {15'd0, ctl_en}, 16'd0);
      chk("rst_done", {15'd0, instr_done}, 16'd0);
      chk("rst_halt", {15'd0, halted}, 16'd0);
      check_icount("rst_icount");
      adv();
      chk("idle_hold", {12'd0, step}, 16'd0);
      chk("idle_ctl", {15'd0, ctl_en}, 16'd0);
   endtask

   task automatic test_free_run();
      int s;
      do_reset();
      start = 1;
      adv();
      start = 0;
      #1;
      for (int i = 0; i < 7; i++) begin
         s = i % 6;
         chk("run_step", {12'd0, step}, 16'(s));
         chk("run_oh", step_oh, 16'd1 << s);
         chk("run_ctl", {15'd0, ctl_en}, 16'd1);
         chk("run_done", {15'd0, instr_done}, (s == 5) ? 16'd1 : 16'd0);
         if (s == 5) exp_icount++;
         adv();
      end
      check_icount("run_icount");
   endtask

   task automatic test_async_reset();
      do_reset();
      start = 1;
      adv();
      start = 0;
      adv(); adv(); adv();
      chk("pre_clr_step", {12'd0, step}, 16'd3);
      nclr = 0;
      #1;
      chk("clr_step", {12'd0, step}, 16'd0);
      chk("clr_oh", step_oh, 16'd0);
      chk("clr_ctl", {15'd0, ctl_en}, 16'd0);
      chk("clr_done", {15'd0, instr_done}, 16'd0);
      adv();
      nclr = 1;
      #1;
      chk("clr_idle_ctl", {15'd0, ctl_en}, 16'd0);
   endtask

   task automatic test_step_end();
      do_reset();
      start = 1;
      adv();
      start = 0;
      adv(); adv();
      step_end = 1;
      #1;
      chk("se_step", {12'd0, step}, 16'd2);
      chk("se_done", {15'd0, instr_done}, 16'd1);
      exp_icount++;
      adv();
      step_end = 0;
      #1;
      chk("se_wrap", {12'd0, step}, 16'd0);
      chk("se_oh", step_oh, 16'd1);
      chk("se_done_lo", {15'd0, instr_done}, 16'd0);
      check_icount("se_icount");
   endtask

   task automatic test_halt();
      do_reset();
      start = 1;
      adv();
      start = 0;
      adv(); adv(); adv(); adv();
      halt_req = 1;
      #1;
      chk("h_step", {12'd0, step}, 16'd4);
      chk("h_ctl", {15'd0, ctl_en}, 16'd1);
      chk("h_done", {15'd0, instr_done}, 16'd0);
      adv();
      chk("h_halted", {15'd0, halted}, 16'd1);
      chk("h_oh", step_oh, 16'd0);
      chk("h_step0", {12'd0, step}, 16'd0);
      chk("h_ctl_lo", {15'd0, ctl_en}, 16'd0);
      chk("h_done_lo", {15'd0, instr_done}, 16'd0);
      adv();
      chk("h_stay", {15'd0, halted}, 16'd1);
      halt_req = 0;
      start = 1;
      adv();
      start = 0;
      #1;
      chk("h_restart_halted", {15'd0, halted}, 16'd0);
      chk("h_restart_step", {12'd0, step}, 16'd0);
      chk("h_restart_oh", step_oh, 16'd1);
      chk("h_restart_ctl", {15'd0, ctl_en}, 16'd1);
      check_icount("h_icount");
   endtask

   task automatic test_single_step();
      int pulses;
      do_reset();
      single = 1;
      start = 1;
      adv();
      start = 0;
      #1;
      chk("ss_pause_step", {12'd0, step}, 16'd0);
      chk("ss_pause_oh", step_oh, 16'd1);
      chk("ss_pause_ctl", {15'd0, ctl_en}, 16'd0);
      adv();
      chk("ss_idle_hold", {12'd0, step}, 16'd0);
      pulses = 0;
      step_btn = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (ctl_en === 1'b1) pulses++;
         adv();
      end
      chk("ss_pulses", 16'(pulses), 16'd1);
      chk("ss_step1", {12'd0, step}, 16'd1);
      chk("ss_oh1", step_oh, 16'd2);
      step_btn = 0;
      adv();
      step_btn = 1;
      #1;
      chk("ss_press2_ctl", {15'd0, ctl_en}, 16'd1);
      adv();
      step_btn = 0;
      #1;
      chk("ss_step2", {12'd0, step}, 16'd2);
      chk("ss_after_ctl", {15'd0, ctl_en}, 16'd0);
      single = 0;
      #1;
      chk("ss_xfer_ctl", {15'd0, ctl_en}, 16'd0);
      adv();
      chk("ss_run_step", {12'd0, step}, 16'd2);
      chk("ss_run_ctl", {15'd0, ctl_en}, 16'd1);
      single = 1;
      adv();
      chk("ss_repause_step", {12'd0, step}, 16'd3);
      chk("ss_repause_ctl", {15'd0, ctl_en}, 16'd0);
      check_icount("ss_icount");
   endtask

   task automatic test_back_to_back();
      do_reset();
      start = 1;
      adv();
      start = 0;
      step_end = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("b2b_step", {12'd0, step}, 16'd0);
         chk("b2b_done", {15'd0, instr_done}, 16'd1);
         exp_icount++;
         adv();
      end
      step_end = 0;
      #1;
      check_icount("b2b_icount");
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_icount = 0;
      test_reset();
      test_free_run();
      test_async_reset();
      test_step_end();
      test_halt();
      test_single_step();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
